// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared constants and helpers for the AXI-Stream adder / accumulator chain.
//   AXIS_WIDTH             : default adder operand width
//   DEFAULT_OPERAND_WIDTH  : alias of AXIS_WIDTH for blocks that take operands
//   DEFAULT_SUM_WIDTH      : adder result width (operand + carry)
//   DEFAULT_ACC_LEN        : default samples per accumulated frame
//   ACC_LEN_MIN/MAX        : supported frame-length range
//   TB_*                   : stimulus limits shared by the benches
//   clog2()                : elaboration-time ceil(log2(value))
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_WIDTH            = 8;
  localparam int DEFAULT_OPERAND_WIDTH = AXIS_WIDTH;
  localparam int DEFAULT_SUM_WIDTH     = DEFAULT_OPERAND_WIDTH + 1;

  localparam int DEFAULT_ACC_LEN = 4;
  localparam int ACC_LEN_MIN     = 2;
  localparam int ACC_LEN_MAX     = 1024;

  localparam int TB_MAX_VALID_DELAY = 3;
  localparam int TB_MAX_READY_DELAY = 3;
  localparam int TB_NUM_FRAMES      = 1000;
  localparam int TB_WATCHDOG_CYCLES = 80000;

  // Bounded loop so the function stays a legal constant function for every
  // tool; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : axis_pkg

// File: rtl/axis_out_reg.sv
// -----------------------------------------------------------------------------
// axis_out_reg
// Single-entry AXI-Stream holding register with load-while-unload, usable as
// a generic register slice.
//   clk_i      : clock, rising edge
//   srst_i     : synchronous active-high reset (drops any held word)
//   s_data_i   : word to load
//   s_valid_i  : load request
//   s_ready_o  : register can take a word this cycle
//   m_data_o   : held word
//   m_valid_o  : held word valid
//   m_ready_i  : downstream accepts the held word
// -----------------------------------------------------------------------------
module axis_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             load;

  // Ready only looks at our own state and the downstream ready, so an
  // upstream valid can never feed back into its own ready.
  assign s_ready_o = !valid_q || m_ready_i;
  assign load      = s_valid_i && s_ready_o;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      // Covers both the empty case and the unload-and-reload case.
      data_d  = s_data_i;
      valid_d = 1'b1;
    end else if (valid_q && m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = valid_q;

endmodule : axis_out_reg

// File: rtl/axis_sum_accumulator.sv
// -----------------------------------------------------------------------------
// axis_sum_accumulator
// Sums incoming AXI-Stream sample words into frames of ACC_LEN samples (or
// shorter when tlast arrives) and emits one total per frame with the sample
// count on tuser. The output is wide enough that a frame total never wraps.
//   aclk           : clock, rising edge
//   areset         : synchronous active-high reset
//   data_i_tdata   : unsigned sample
//   data_i_tvalid  : sample valid
//   data_i_tlast   : close the frame with this sample
//   data_i_tready  : sample accepted when high with tvalid
//   data_o_tdata   : unsigned frame total
//   data_o_tuser   : samples in the frame (1..ACC_LEN)
//   data_o_tvalid  : total valid
//   data_o_tready  : downstream ready
// -----------------------------------------------------------------------------
module axis_sum_accumulator
  import axis_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_SUM_WIDTH,
  parameter  int ACC_LEN    = DEFAULT_ACC_LEN,
  localparam int OUT_WIDTH  = DATA_WIDTH + clog2(ACC_LEN),
  localparam int CNT_WIDTH  = clog2(ACC_LEN + 1)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] data_i_tdata,
  input  logic                  data_i_tvalid,
  input  logic                  data_i_tlast,
  output logic                  data_i_tready,
  output logic [OUT_WIDTH-1:0]  data_o_tdata,
  output logic [CNT_WIDTH-1:0]  data_o_tuser,
  output logic                  data_o_tvalid,
  input  logic                  data_o_tready
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);
  localparam int                   PACK_W   = CNT_WIDTH + OUT_WIDTH;

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 in_hs;
  logic                 closing;
  logic [OUT_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [PACK_W-1:0]    frame_word;
  logic [PACK_W-1:0]    out_word;

  assign in_hs   = data_i_tvalid && data_i_tready;
  assign closing = data_i_tlast || (cnt_q == LAST_CNT);

  // Zero-extend before adding; OUT_WIDTH already holds ACC_LEN full-scale
  // samples, so the carry out of this add is always zero.
  assign sum     = acc_q + OUT_WIDTH'(data_i_tdata);
  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_hs) begin
      if (closing) begin
        // The total leaves through the output register; start a new frame.
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // tuser rides alongside the total in the same holding register so both
  // stay frozen together under backpressure.
  assign frame_word = {cnt_inc, sum};

  // The register's own ready gates the load, so presenting a closing sample
  // while the register is stuck cannot overwrite the held total.
  axis_out_reg #(
    .WIDTH (PACK_W)
  ) u_out_reg (
    .clk_i     (aclk),
    .srst_i    (areset),
    .s_data_i  (frame_word),
    .s_valid_i (data_i_tvalid && closing),
    .s_ready_o (data_i_tready),
    .m_data_o  (out_word),
    .m_valid_o (data_o_tvalid),
    .m_ready_i (data_o_tready)
  );

  assign data_o_tuser = out_word[PACK_W-1:OUT_WIDTH];
  assign data_o_tdata = out_word[OUT_WIDTH-1:0];

endmodule : axis_sum_accumulator

// File: tb/tb_axis_sum_accumulator.sv
module tb_axis_sum_accumulator;
  import axis_pkg::*;

  localparam int DW = 9;
  localparam int AL = 4;
  localparam int OW = DW + 2;
  localparam int CW = 3;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] user;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] data_i_tdata;
  logic          data_i_tvalid;
  logic          data_i_tlast;
  logic          data_i_tready;
  logic [OW-1:0] data_o_tdata;
  logic [CW-1:0] data_o_tuser;
  logic          data_o_tvalid;
  logic          data_o_tready;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   cycle         = 0;
  logic rand_done;

  always #5 aclk = ~aclk;

  axis_sum_accumulator #(
    .DATA_WIDTH (DW),
    .ACC_LEN    (AL)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .data_i_tdata  (data_i_tdata),
    .data_i_tvalid (data_i_tvalid),
    .data_i_tlast  (data_i_tlast),
    .data_i_tready (data_i_tready),
    .data_o_tdata  (data_o_tdata),
    .data_o_tuser  (data_o_tuser),
    .data_o_tvalid (data_o_tvalid),
    .data_o_tready (data_o_tready)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic expect_frame(input int total, input int count);
    exp_t e;
    e.data = OW'(total);
    e.user = CW'(count);
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input logic l);
    logic hs;
    int   waited;
    waited        = 0;
    data_i_tdata  = DW'(d);
    data_i_tlast  = l;
    data_i_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      hs = data_i_tready;
      @(posedge aclk);
      #1;
      if (hs) break;
      waited++;
      if (waited > 1000) begin
        checks_total++;
        $display("FAIL send_timeout: sample %0d not accepted after %0d cycles", d, waited);
        break;
      end
    end
    data_i_tvalid = 1'b0;
    data_i_tlast  = 1'b0;
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Monitor: an output handshake happens at the next edge when both are high.
  always @(negedge aclk) begin
    if (!areset && data_o_tvalid && data_o_tready) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("FAIL unexpected_output: got tdata %0d tuser %0d, expected none", data_o_tdata, data_o_tuser);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_tdata", data_o_tdata, mon_e.data);
        check("frame_tuser", data_o_tuser, mon_e.user);
      end
    end
  end

  always @(posedge aclk) begin
    cycle <= cycle + 1;
    if (cycle > TB_WATCHDOG_CYCLES) begin
      checks_total++;
      $display("FAIL watchdog: ran %0d cycles, limit %0d", cycle, TB_WATCHDOG_CYCLES);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
    end
  end

  initial begin
    int c0;
    int samples[4];
    int len;
    int total;
    int gap;
    logic last;

    areset        = 1'b1;
    data_i_tdata  = '0;
    data_i_tvalid = 1'b0;
    data_i_tlast  = 1'b0;
    data_o_tready = 1'b0;
    rand_done     = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk);
      #1;
      data_i_tdata  = DW'($urandom_range(0, 511));
      data_i_tvalid = 1'($urandom_range(0, 1));
      data_i_tlast  = 1'($urandom_range(0, 1));
      data_o_tready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      check("reset_tvalid", data_o_tvalid, 0);
      check("reset_tdata", data_o_tdata, 0);
      check("reset_tuser", data_o_tuser, 0);
    end
    @(posedge aclk);
    #1;
    areset        = 1'b0;
    data_i_tvalid = 1'b0;
    data_i_tlast  = 1'b0;
    data_o_tready = 1'b1;
    @(negedge aclk);
    check("tready_after_reset", data_i_tready, 1);
    @(posedge aclk);
    #1;

    // Basic frame and one-cycle latency.
    expect_frame(10, 4);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    check("latency_tvalid", data_o_tvalid, 1);
    check("latency_tdata", data_o_tdata, 10);

    // Full-scale samples need the extra output bits.
    expect_frame(2044, 4);
    send(511, 0); send(511, 0); send(511, 0); send(511, 0);

    // Early close, then a full frame.
    expect_frame(16, 2);
    expect_frame(20, 4);
    send(7, 0); send(9, 1);
    send(5, 0); send(5, 0); send(5, 0); send(5, 0);

    // tlast on the first sample and on the ACC_LEN-th sample.
    expect_frame(5, 1);
    send(5, 1);
    expect_frame(1000, 4);
    send(100, 0); send(200, 0); send(300, 0); send(400, 1);

    // Throughput: two frames back-to-back, one sample per cycle.
    expect_frame(26, 4);
    expect_frame(8, 4);
    c0 = cycle;
    send(2, 0); send(4, 0); send(8, 0); send(12, 0);
    send(1, 0); send(2, 0); send(2, 0); send(3, 0);
    check("throughput_cycles", cycle - c0, 8);
    drain(20);

    // Backpressure: total held, input stalled, next frame not lost.
    data_o_tready = 1'b0;
    expect_frame(10, 4);
    expect_frame(4, 4);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    fork
      begin
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
      end
      begin
        repeat (6) begin
          @(negedge aclk);
          check("bp_tvalid", data_o_tvalid, 1);
          check("bp_tdata", data_o_tdata, 10);
          check("bp_in_tready", data_i_tready, 0);
        end
        @(posedge aclk);
        #1;
        data_o_tready = 1'b1;
      end
    join
    drain(20);

    // Mid-frame reset discards the partial sum.
    send(3, 0); send(3, 0);
    pulse_reset();
    expect_frame(10, 4);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    drain(20);

    // Reset while holding drops the pending total.
    data_o_tready = 1'b0;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    check("hold_tvalid", data_o_tvalid, 1);
    pulse_reset();
    @(negedge aclk);
    check("hold_reset_tvalid", data_o_tvalid, 0);
    check("hold_reset_tdata", data_o_tdata, 0);
    check("hold_reset_tuser", data_o_tuser, 0);
    check("hold_reset_in_tready", data_i_tready, 1);
    @(posedge aclk);
    #1;

    // Random chain: sums of two random 8-bit operands, random frame lengths,
    // random valid gaps and random downstream ready.
    fork
      begin
        for (int f = 0; f < TB_NUM_FRAMES; f++) begin
          len   = $urandom_range(1, AL);
          total = 0;
          for (int i = 0; i < len; i++) begin
            samples[i] = $urandom_range(0, 255) + $urandom_range(0, 255);
            total += samples[i];
          end
          expect_frame(total, len);
          for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, TB_MAX_VALID_DELAY);
            repeat (gap) begin
              @(posedge aclk);
              #1;
            end
            last = (i == len - 1) && ((len < AL) || ($urandom_range(0, 1) == 1));
            send(samples[i], last);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          data_o_tready = ($urandom_range(0, TB_MAX_READY_DELAY) < 2);
          @(posedge aclk);
          #1;
        end
        data_o_tready = 1'b1;
      end
    join
    drain(200);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_axis_sum_accumulator
